demux_stream_1xn: RTL and testbench
===================================

# demux_stream_1xn

Parametrised 1-to-N stream demultiplexer with a valid/ready handshake on every port. It succeeds the fixed-width combinational 1x16 demux, and adds:
- a registered holding stage;
- per-channel backpressure;
- a broadcast mode that delivers one word to all N outputs independently.

It sits between a single producer and N consumer channels, such as per-lane FIFOs or engines.

## Interface
- DATA_W, 8, payload width in bits (>=1)
- SEL_W, 4, select width; N = 2**SEL_W output channels (1..6)

- clk  input  1  clock; all logic is rising-edge
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle
- in_data  input  DATA_W  payload
- in_sel  input  SEL_W  destination channel index, used when in_bcast=0
- in_bcast  input  1  1 = deliver the word to all N channels
- out_valid  output  N  per-channel valid; bit i addresses channel i
- out_ready  input  N  per-channel ready
- out_data  output  DATA_W  shared payload bus, valid on every channel whose out_valid bit is set
- busy  output  1  holding stage occupied; equals |pend

## Operation
- State:
  - data register hold (DATA_W);
  - pending mask pend (N bits).
  - Two states: IDLE (pend==0) and HOLD (pend!=0).
- out_valid = pend and out_data = hold, both driven directly from registers.
- Channel handshake: channel i completes when pend[i] & out_ready[i]. Completion clears pend[i] on the next edge.
- drain = (pend & ~out_ready) == 0, i.e. every pending channel completes this cycle. drain is true when pend==0.
- in_ready = rst_n & drain. This is combinational from out_ready. There is no combinational path from in_valid to in_ready.
- Input accept occurs when in_valid & in_ready. On accept:
  - hold <= in_data;
  - pend <= all-ones if in_bcast, else one-hot(in_sel).
- Accept and drain in the same cycle is legal. The new mask replaces the old one; the old word is never duplicated or lost.
- No accept, with some channels completing: pend <= pend & ~out_ready.
- Broadcast: each channel takes the word independently, in any order and on any cycle. The next input is accepted only in the cycle that the last pending channel completes.
- Channels with pend[i]=0 ignore out_ready[i].
- hold changes only on accept. It is not cleared when pend empties.
- in_sel and in_bcast are sampled only on accept. in_sel is ignored when in_bcast=1.
- in_valid may deassert without an accept. The block keeps no memory of unaccepted words.
- Reset (rst_n=0 at an edge):
  - pend <= 0 and hold <= 0, so out_valid=0, out_data=0 and busy=0.
  - in_ready=0 while rst_n is low.
  - A word in HOLD is discarded, including a partially delivered broadcast.
  - No handshake is honoured in the cycle that reset is sampled.

## Timing
- Latency: a word accepted at edge k appears on out_valid/out_data from edge k, i.e. visible in cycle k+1.
- Throughput: 1 word per cycle when the target channels keep out_ready high.
- Broadcast with all out_ready=1 also completes in 1 cycle.
- In HOLD, out_valid and out_data are stable until the channel completes. This satisfies the AXI-stream-style rule that a valid may not drop without a handshake.
- The first accept is possible in the first cycle after rst_n rises.
- X on in_sel or in_bcast while in_valid=0 must not propagate to any state.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with random inputs.
  - Required: out_valid=0, out_data=0, busy=0 and in_ready=0 throughout.
  - After release with out_ready=all-ones: in_ready=1.
- Unicast: send in_sel=5, data=0xA5, out_ready=all-ones.
  - Next cycle: out_valid=0x0020, out_data=0xA5.
  - Back-to-back sends to sel 0,15,3 give one-hot out_valid in consecutive cycles with no bubbles.
- Backpressure: sel=2, data=0x3C, out_ready[2]=0 for 4 cycles.
  - Required: out_valid[2] and out_data=0x3C stable, in_ready=0 for those 4 cycles.
  - Raise out_ready[2]: in_ready=1 in that same cycle, and a waiting word 0x3D is accepted that cycle.
- Broadcast with staggered ready (N=16): send data=0x77 with in_bcast=1. Raise out_ready one channel per cycle, order 15..0.
  - out_valid goes 0xFFFF, 0x7FFF, 0x3FFF, ... down to 0x0000.
  - in_ready is asserted only in the cycle channel 0 completes.
  - Every channel sees 0x77 exactly once.
- Simultaneous drain and accept: broadcast pending on channels {1,4} only, both ready, in_valid=1 with sel=9, data=0x12.
  - Next cycle: out_valid=0x0200, out_data=0x12, no repeat on 1/4.
- Reset mid-operation: broadcast 0xEE and let 5 channels complete, then assert rst_n=0 for 1 cycle.
  - After the reset edge: out_valid=0, busy=0.
  - After release: no channel ever receives 0xEE.

Source files
------------

// File: rtl/demux_stream_1xn.sv
// 1-to-N valid/ready stream demultiplexer with a registered holding stage,
// per-channel backpressure and a broadcast mode.
module demux_stream_1xn #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 4,
  localparam int unsigned N     = 2 ** SEL_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_bcast,
  output logic [N-1:0]      out_valid,
  input  logic [N-1:0]      out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [N-1:0]        pend_q, pend_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                drain_c;
  logic                accept_c;

  // Upstream may only load when every pending channel finishes this cycle.
  always_comb begin
    drain_c  = ~|(pend_q & ~out_ready);
    in_ready = rst_n & drain_c;
    accept_c = in_valid & in_ready;
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q & ~out_ready;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          hold_d  = in_data;
          pend_d  = in_bcast ? {N{1'b1}} : N'(1) << in_sel;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // A new mask replaces the drained one when accept and drain coincide.
        if (accept_c) begin
          hold_d  = in_data;
          pend_d  = in_bcast ? {N{1'b1}} : N'(1) << in_sel;
          state_d = HOLD;
        end else if (pend_d == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      hold_q  <= hold_d;
    end
  end

  assign out_valid = pend_q;
  assign out_data  = hold_q;
  assign busy      = (state_q == HOLD);

endmodule

// File: tb/tb_demux_stream_1xn.sv
// Directed self-checking bench for demux_stream_1xn (DATA_W=8, N=16).
module tb_demux_stream_1xn;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned SEL_W  = 4;
  localparam int unsigned N      = 16;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [SEL_W-1:0]  in_sel;
  logic              in_bcast;
  logic [N-1:0]      out_valid;
  logic [N-1:0]      out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;

  int tests = 0;
  int fails = 0;
  int cnt [N][256];
  int total;

  demux_stream_1xn #(.DATA_W(DATA_W), .SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-channel record of every completed handshake, keyed by payload.
  initial begin
    for (int c = 0; c < N; c++)
      for (int d = 0; d < 256; d++) cnt[c][d] = 0;
  end
  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      for (int c = 0; c < N; c++)
        if (out_valid[c] && out_ready[c]) cnt[c][out_data] = cnt[c][out_data] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [SEL_W-1:0] s,
                       input logic [DATA_W-1:0] d, input logic b);
    in_valid = v;
    in_sel   = s;
    in_data  = d;
    in_bcast = b;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = '0;
    drive(1'b0, '0, '0, 1'b0);
    tick();

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 4'($urandom), 8'($urandom), 1'($urandom));
      out_ready = 16'($urandom);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
    end
    rst_n     = 1'b1;
    out_ready = '1;
    drive(1'b0, '0, '0, 1'b0);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Unicast, then back-to-back to 0, 15, 3
    drive(1'b1, 4'd5, 8'hA5, 1'b0);
    tick();
    check("uni_valid", 32'(out_valid), 32'h0020);
    check("uni_data", 32'(out_data), 32'hA5);
    drive(1'b1, 4'd0, 8'h10, 1'b0);
    #1;
    check("uni_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("b2b0_valid", 32'(out_valid), 32'h0001);
    check("b2b0_data", 32'(out_data), 32'h10);
    drive(1'b1, 4'd15, 8'h1F, 1'b0);
    tick();
    check("b2b15_valid", 32'(out_valid), 32'h8000);
    check("b2b15_data", 32'(out_data), 32'h1F);
    drive(1'b1, 4'd3, 8'h33, 1'b0);
    tick();
    check("b2b3_valid", 32'(out_valid), 32'h0008);
    check("b2b3_data", 32'(out_data), 32'h33);
    drive(1'b0, 4'd3, 8'h33, 1'b0);
    tick();
    check("uni_drained", 32'(out_valid), 32'h0000);
    check("uni_busy", 32'(busy), 32'd0);
    check("uni_data_kept", 32'(out_data), 32'h33);

    // Backpressure on channel 2 with 0x3D waiting
    out_ready = ~16'h0004;
    drive(1'b1, 4'd2, 8'h3C, 1'b0);
    tick();
    drive(1'b1, 4'd7, 8'h3D, 1'b0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_valid", 32'(out_valid), 32'h0004);
      check("bp_data", 32'(out_data), 32'h3C);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    out_ready = '1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("bp_next_valid", 32'(out_valid), 32'h0080);
    check("bp_next_data", 32'(out_data), 32'h3D);
    check("bp_3c_once", 32'(cnt[2][8'h3C]), 32'd1);
    tick();
    check("bp_drained", 32'(out_valid), 32'h0000);

    // Broadcast with staggered ready 15..0 (in_sel must be ignored)
    out_ready = '0;
    drive(1'b1, 4'd5, 8'h77, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("bc_valid_full", 32'(out_valid), 32'hFFFF);
    check("bc_data", 32'(out_data), 32'h77);
    for (int i = 15; i >= 0; i--) begin
      out_ready = 16'(1) << i;
      #1;
      check("bc_in_ready", 32'(in_ready), (i == 0) ? 32'd1 : 32'd0);
      tick();
      check("bc_valid_step", 32'(out_valid), (32'd1 << i) - 32'd1);
    end
    for (int c = 0; c < N; c++)
      check($sformatf("bc_once_ch%0d", c), 32'(cnt[c][8'h77]), 32'd1);
    check("bc_busy_end", 32'(busy), 32'd0);

    // Drain of {1,4} coincides with accept of a unicast to 9
    out_ready = '0;
    drive(1'b1, 4'd0, 8'h55, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    out_ready = ~16'h0012;
    tick();
    check("sim_pending", 32'(out_valid), 32'h0012);
    out_ready = 16'h0012;
    drive(1'b1, 4'd9, 8'h12, 1'b0);
    #1;
    check("sim_in_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    check("sim_valid", 32'(out_valid), 32'h0200);
    check("sim_data", 32'(out_data), 32'h12);
    out_ready = '1;
    tick();
    check("sim_ch1_once", 32'(cnt[1][8'h55]), 32'd1);
    check("sim_ch4_once", 32'(cnt[4][8'h55]), 32'd1);
    check("sim_ch9_once", 32'(cnt[9][8'h12]), 32'd1);
    check("sim_drained", 32'(out_valid), 32'h0000);

    // Reset in the middle of a broadcast after 5 channels took it
    out_ready = '0;
    drive(1'b1, 4'd0, 8'hEE, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    out_ready = 16'h001F;
    tick();
    check("mid_pending", 32'(out_valid), 32'hFFE0);
    out_ready = '0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    check("mid_rst_valid", 32'(out_valid), 32'h0000);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_data", 32'(out_data), 32'h00);
    rst_n     = 1'b1;
    out_ready = '1;
    tick();
    tick();
    check("mid_post_valid", 32'(out_valid), 32'h0000);
    total = 0;
    for (int c = 0; c < N; c++) total += cnt[c][8'hEE];
    check("mid_ee_total", 32'(total), 32'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
